// File: rtl/mc_control_fsm_if.sv
// Control bus between the multicycle main controller and the MIPS datapath.
// The controller is the master: it consumes en/opcode and drives every strobe and select.
interface mc_control_fsm_if;
  logic       en;
  logic [5:0] opcode;
  logic [1:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic [3:0] state;
  logic       illegal_op;

  modport master (
    input  en, opcode,
    output alu_op, alu_src_a, alu_src_b, pc_write, pc_write_cond, pc_source,
           i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
           state, illegal_op
  );

  modport slave (
    output en, opcode,
    input  alu_op, alu_src_a, alu_src_b, pc_write, pc_write_cond, pc_source,
           i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
           state, illegal_op
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control: sequences fetch/decode/execute/memory/writeback
// and drives the datapath strobes as a Moore decode of the current state.
module mc_control_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic                clk,
  input  logic                rst_n,
  mc_control_fsm_if.master    bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_e;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
  } ctrl_t;

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   illegal_q, illegal_d;
  ctrl_t  ctrl_out;

  function automatic ctrl_t decode(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = 2'b01;
        c.pc_write  = 1'b1;
      end
      DECODE: c.alu_src_b = 2'b11;
      MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      MEMRD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      ADDIWB: c.reg_write = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Opcode is only looked at in DECODE and MEMADR; the IR is stable after FETCH.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    if (bus.en) begin
      case (state_q)
        FETCH:  state_d = DECODE;
        DECODE: begin
          case (bus.opcode)
            OP_LW, OP_SW: state_d = MEMADR;
            OP_RTYPE:     state_d = EXEC;
            OP_BEQ:       state_d = BRANCH;
            OP_J:         state_d = JUMP;
            OP_ADDI:      state_d = ADDIEX;
            default: begin
              state_d   = FETCH;
              illegal_d = 1'b1;
            end
          endcase
        end
        MEMADR: begin
          if (bus.opcode == OP_LW)      state_d = MEMRD;
          else if (bus.opcode == OP_SW) state_d = MEMWR;
          else                          state_d = FETCH;
        end
        MEMRD:  state_d = MEMWB;
        EXEC:   state_d = ALUWB;
        ADDIEX: state_d = ADDIWB;
        default: state_d = FETCH;
      endcase
    end
    ctrl_d = decode(state_d);
  end

  // Outputs are registered from the next-state decode, so ctrl_q always equals
  // decode(state_q); the reset value is the FETCH decode for the cycle after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      ctrl_q    <= decode(FETCH);
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  // Reset must silence every strobe and select at once, without waiting for an edge.
  assign ctrl_out = rst_n ? ctrl_q : '0;

  assign bus.alu_op        = ctrl_out.alu_op;
  assign bus.alu_src_a     = ctrl_out.alu_src_a;
  assign bus.alu_src_b     = ctrl_out.alu_src_b;
  assign bus.pc_write      = ctrl_out.pc_write;
  assign bus.pc_write_cond = ctrl_out.pc_write_cond;
  assign bus.pc_source     = ctrl_out.pc_source;
  assign bus.i_or_d        = ctrl_out.i_or_d;
  assign bus.mem_read      = ctrl_out.mem_read;
  assign bus.mem_write     = ctrl_out.mem_write;
  assign bus.ir_write      = ctrl_out.ir_write;
  assign bus.mem_to_reg    = ctrl_out.mem_to_reg;
  assign bus.reg_dst       = ctrl_out.reg_dst;
  assign bus.reg_write     = ctrl_out.reg_write;
  assign bus.state         = state_q;
  assign bus.illegal_op    = illegal_q;

endmodule
